module_11: RTL and testbench

Second radix-2 butterfly stage of the 512-point FFT pipeline. It sits directly after `module_10` and consumes that stage's twiddled sum/diff streams. For each 16-cycle input burst it pairs cycle k with cycle k+DEPTH in both streams and computes the butterfly. It applies the trivial −j twiddle to the diff-stream differences and emits 16 output cycles of 16 lanes to the next stage.

---
 rtl/module_11.sv | 172 +++++++++++++++++
 tb/tb_module_11.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/module_11.sv
// module_11: second radix-2 butterfly stage of the 512-point FFT pipeline.
// Pairs cycle k with k+DEPTH of each burst; diff-stream results are drained after the sum results.
module module_11 #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic signed [WIDTH-1:0] din_sum_re  [0:15],
  input  logic signed [WIDTH-1:0] din_sum_im  [0:15],
  input  logic signed [WIDTH-1:0] din_diff_re [0:15],
  input  logic signed [WIDTH-1:0] din_diff_im [0:15],
  input  logic                    din_valid,
  output logic signed [WIDTH:0]   dout_add_re [0:15],
  output logic signed [WIDTH:0]   dout_add_im [0:15],
  output logic signed [WIDTH:0]   dout_sub_re [0:15],
  output logic signed [WIDTH:0]   dout_sub_im [0:15],
  output logic                    dout_valid
);

  localparam int LANES = 16;
  localparam int CW    = $clog2(2 * DEPTH);
  localparam int SW    = $clog2(DEPTH);

  typedef logic signed [WIDTH-1:0] smp_t;
  typedef logic signed [WIDTH:0]   ext_t;

  function automatic ext_t sext(input smp_t v);
    return ext_t'(v);
  endfunction

  // a-b lies in [-2^WIDTH+1, 2^WIDTH-1], so negation stays in range.
  function automatic ext_t neg(input ext_t v);
    return -v;
  endfunction

  // ---------------------------------------------------------------- control
  logic [CW-1:0] r_in_cnt;
  logic          r_drain_act;
  logic [SW-1:0] r_drain_cnt;

  logic          w_fill_phase;
  logic          w_fill;
  logic          w_calc;
  logic          w_cnt_last;
  logic          w_calc_last;
  logic [SW-1:0] w_slot;

  assign w_fill_phase = (r_in_cnt < CW'(DEPTH));
  assign w_fill       = din_valid && w_fill_phase;
  assign w_calc       = din_valid && !w_fill_phase;
  assign w_cnt_last   = (r_in_cnt == CW'(2 * DEPTH - 1));
  assign w_calc_last  = w_calc && w_cnt_last;
  assign w_slot       = SW'(w_fill_phase ? r_in_cnt : r_in_cnt - CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_in_cnt    <= '0;
      r_drain_act <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      if (din_valid) begin
        r_in_cnt <= w_cnt_last ? '0 : r_in_cnt + CW'(1);
      end
      if (w_calc_last) begin
        r_drain_act <= 1'b1;
        r_drain_cnt <= '0;
      end else if (r_drain_act) begin
        if (r_drain_cnt == SW'(DEPTH - 1)) begin
          r_drain_act <= 1'b0;
        end
        r_drain_cnt <= r_drain_cnt + SW'(1);
      end
    end
  end

  // ---------------------------------------------------------------- p0: buffers and butterfly
  smp_t r_ibuf_sre [DEPTH][LANES];
  smp_t r_ibuf_sim [DEPTH][LANES];
  smp_t r_ibuf_dre [DEPTH][LANES];
  smp_t r_ibuf_dim [DEPTH][LANES];

  ext_t r_dbuf_xre [DEPTH][LANES];
  ext_t r_dbuf_xim [DEPTH][LANES];
  ext_t r_dbuf_yre [DEPTH][LANES];
  ext_t r_dbuf_yim [DEPTH][LANES];

  ext_t w_add_re_p0 [LANES];
  ext_t w_add_im_p0 [LANES];
  ext_t w_sub_re_p0 [LANES];
  ext_t w_sub_im_p0 [LANES];
  ext_t w_dx_re_p0  [LANES];
  ext_t w_dx_im_p0  [LANES];
  ext_t w_dy_re_p0  [LANES];
  ext_t w_dy_im_p0  [LANES];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_add_re_p0[i] = sext(r_ibuf_sre[w_slot][i]) + sext(din_sum_re[i]);
      w_add_im_p0[i] = sext(r_ibuf_sim[w_slot][i]) + sext(din_sum_im[i]);
      w_sub_re_p0[i] = sext(r_ibuf_sre[w_slot][i]) - sext(din_sum_re[i]);
      w_sub_im_p0[i] = sext(r_ibuf_sim[w_slot][i]) - sext(din_sum_im[i]);
      w_dx_re_p0[i]  = sext(r_ibuf_dre[w_slot][i]) + sext(din_diff_re[i]);
      w_dx_im_p0[i]  = sext(r_ibuf_dim[w_slot][i]) + sext(din_diff_im[i]);
      // (a-b)*(-j): real takes the imaginary difference, imaginary the negated real one.
      w_dy_re_p0[i]  = sext(r_ibuf_dim[w_slot][i]) - sext(din_diff_im[i]);
      w_dy_im_p0[i]  = neg(sext(r_ibuf_dre[w_slot][i]) - sext(din_diff_re[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      for (int i = 0; i < LANES; i++) begin
        r_ibuf_sre[w_slot][i] <= din_sum_re[i];
        r_ibuf_sim[w_slot][i] <= din_sum_im[i];
        r_ibuf_dre[w_slot][i] <= din_diff_re[i];
        r_ibuf_dim[w_slot][i] <= din_diff_im[i];
      end
    end
    if (w_calc) begin
      for (int i = 0; i < LANES; i++) begin
        r_dbuf_xre[w_slot][i] <= w_dx_re_p0[i];
        r_dbuf_xim[w_slot][i] <= w_dx_im_p0[i];
        r_dbuf_yre[w_slot][i] <= w_dy_re_p0[i];
        r_dbuf_yim[w_slot][i] <= w_dy_im_p0[i];
      end
    end
  end

  // ---------------------------------------------------------------- p1: output registers
  ext_t r_add_re_p1 [LANES];
  ext_t r_add_im_p1 [LANES];
  ext_t r_sub_re_p1 [LANES];
  ext_t r_sub_im_p1 [LANES];
  logic r_vld_p1;

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_vld_p1 <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        r_add_re_p1[i] <= '0;
        r_add_im_p1[i] <= '0;
        r_sub_re_p1[i] <= '0;
        r_sub_im_p1[i] <= '0;
      end
    end else begin
      r_vld_p1 <= r_drain_act || w_calc;
      if (r_drain_act) begin
        for (int i = 0; i < LANES; i++) begin
          r_add_re_p1[i] <= r_dbuf_xre[r_drain_cnt][i];
          r_add_im_p1[i] <= r_dbuf_xim[r_drain_cnt][i];
          r_sub_re_p1[i] <= r_dbuf_yre[r_drain_cnt][i];
          r_sub_im_p1[i] <= r_dbuf_yim[r_drain_cnt][i];
        end
      end else if (w_calc) begin
        for (int i = 0; i < LANES; i++) begin
          r_add_re_p1[i] <= w_add_re_p0[i];
          r_add_im_p1[i] <= w_add_im_p0[i];
          r_sub_re_p1[i] <= w_sub_re_p0[i];
          r_sub_im_p1[i] <= w_sub_im_p0[i];
        end
      end
    end
  end

  assign dout_add_re = r_add_re_p1;
  assign dout_add_im = r_add_im_p1;
  assign dout_sub_re = r_sub_re_p1;
  assign dout_sub_im = r_sub_im_p1;
  assign dout_valid  = r_vld_p1;

endmodule

// File: tb/tb_module_11.sv
// Testbench for module_11: directed bursts with a queue scoreboard fed by a
// behavioural butterfly model and drained by a negedge output monitor.
module tb_module_11;

  localparam int W = 12;
  localparam int D = 8;
  localparam int L = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din_valid = 1'b0;
  logic signed [W-1:0] s_re [0:L-1];
  logic signed [W-1:0] s_im [0:L-1];
  logic signed [W-1:0] d_re [0:L-1];
  logic signed [W-1:0] d_im [0:L-1];
  logic signed [W:0]   o_add_re [0:L-1];
  logic signed [W:0]   o_add_im [0:L-1];
  logic signed [W:0]   o_sub_re [0:L-1];
  logic signed [W:0]   o_sub_im [0:L-1];
  logic                o_valid;

  typedef struct packed {
    logic [L-1:0][W:0] add_re;
    logic [L-1:0][W:0] add_im;
    logic [L-1:0][W:0] sub_re;
    logic [L-1:0][W:0] sub_im;
  } res_t;

  res_t q [$];
  res_t m_diff [0:D-1];
  res_t mon_obs;
  res_t mon_exp;
  int   m_sre [0:D-1][0:L-1];
  int   m_sim [0:D-1][0:L-1];
  int   m_dre [0:D-1][0:L-1];
  int   m_dim [0:D-1][0:L-1];
  int   m_cnt = 0;
  int   m_drain = 0;
  int   vld_seen = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  module_11 #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rstn(rst),
    .din_sum_re(s_re), .din_sum_im(s_im),
    .din_diff_re(d_re), .din_diff_im(d_im),
    .din_valid(din_valid),
    .dout_add_re(o_add_re), .dout_add_im(o_add_im),
    .dout_sub_re(o_sub_re), .dout_sub_im(o_sub_im),
    .dout_valid(o_valid)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [L*(W+1)-1:0] obs, input logic [L*(W+1)-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output monitor: every valid output must match the oldest expected result.
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      chk("sb_pending", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        mon_exp = q.pop_front();
        for (int i = 0; i < L; i++) begin
          mon_obs.add_re[i] = o_add_re[i];
          mon_obs.add_im[i] = o_add_im[i];
          mon_obs.sub_re[i] = o_sub_re[i];
          mon_obs.sub_im[i] = o_sub_im[i];
        end
        chkv("add_re", mon_obs.add_re, mon_exp.add_re);
        chkv("add_im", mon_obs.add_im, mon_exp.add_im);
        chkv("sub_re", mon_obs.sub_re, mon_exp.sub_re);
        chkv("sub_im", mon_obs.sub_im, mon_exp.sub_im);
      end
    end
  end

  // One clock of stimulus: update the model, advance, then check dout_valid.
  task automatic tick(input logic v);
    logic exp_v;
    int   j;
    int   dr;
    int   di;
    res_t e;
    din_valid = v;
    exp_v = (m_drain > 0) || (v && m_cnt >= D);
    if (m_drain > 0) m_drain--;
    if (v) begin
      if (m_cnt < D) begin
        for (int i = 0; i < L; i++) begin
          m_sre[m_cnt][i] = int'(s_re[i]);
          m_sim[m_cnt][i] = int'(s_im[i]);
          m_dre[m_cnt][i] = int'(d_re[i]);
          m_dim[m_cnt][i] = int'(d_im[i]);
        end
      end else begin
        j = m_cnt - D;
        for (int i = 0; i < L; i++) begin
          e.add_re[i] = 13'(m_sre[j][i] + int'(s_re[i]));
          e.add_im[i] = 13'(m_sim[j][i] + int'(s_im[i]));
          e.sub_re[i] = 13'(m_sre[j][i] - int'(s_re[i]));
          e.sub_im[i] = 13'(m_sim[j][i] - int'(s_im[i]));
          dr = m_dre[j][i] - int'(d_re[i]);
          di = m_dim[j][i] - int'(d_im[i]);
          m_diff[j].add_re[i] = 13'(m_dre[j][i] + int'(d_re[i]));
          m_diff[j].add_im[i] = 13'(m_dim[j][i] + int'(d_im[i]));
          m_diff[j].sub_re[i] = 13'(di);
          m_diff[j].sub_im[i] = 13'(-dr);
        end
        q.push_back(e);
        if (m_cnt == 2 * D - 1) begin
          for (int s = 0; s < D; s++) q.push_back(m_diff[s]);
          m_drain = D;
        end
      end
      m_cnt = (m_cnt + 1) % (2 * D);
    end
    @(posedge clk);
    #1;
    if (o_valid === 1'b1) vld_seen++;
    chk("dout_valid", 32'(o_valid), 32'(exp_v));
  endtask

  task automatic clear_in();
    for (int i = 0; i < L; i++) begin
      s_re[i] = '0; s_im[i] = '0; d_re[i] = '0; d_im[i] = '0;
    end
  endtask

  task automatic rand_in();
    for (int i = 0; i < L; i++) begin
      s_re[i] = W'($urandom_range(4095, 0));
      s_im[i] = W'($urandom_range(4095, 0));
      d_re[i] = W'($urandom_range(4095, 0));
      d_im[i] = W'($urandom_range(4095, 0));
    end
  endtask

  task automatic do_reset();
    logic [W:0] acc;
    din_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_cnt = 0;
    m_drain = 0;
    q.delete();
    acc = '0;
    for (int i = 0; i < L; i++) acc = acc | o_add_re[i] | o_add_im[i] | o_sub_re[i] | o_sub_im[i];
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_dout_zero", 32'(acc), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Impulse on sum lane 0
    for (int k = 0; k < 2 * D; k++) begin
      clear_in();
      if (k == 0) s_re[0] = W'(100);
      tick(1'b1);
      if (k == D) begin
        chk("imp_add_re0", 32'(o_add_re[0]), 100);
        chk("imp_sub_re0", 32'(o_sub_re[0]), 100);
      end
    end
    clear_in();
    repeat (10) tick(1'b0);

    // -j twiddle on diff lane 3
    for (int k = 0; k < 2 * D; k++) begin
      clear_in();
      if (k == 2)  begin d_re[3] = W'(300); d_im[3] = W'(-50); end
      if (k == 10) begin d_re[3] = W'(100); d_im[3] = W'(20);  end
      tick(1'b1);
    end
    clear_in();
    for (int k = 2 * D; k < 2 * D + 10; k++) begin
      tick(1'b0);
      if (k == 18) begin
        chk("tw_add_re3", 32'(o_add_re[3]), 400);
        chk("tw_add_im3", 32'(o_add_im[3]), -30);
        chk("tw_sub_re3", 32'(o_sub_re[3]), -70);
        chk("tw_sub_im3", 32'(o_sub_im[3]), -200);
      end
    end

    // Extremes: a = -2048, b = 2047, diff imaginary zero
    for (int k = 0; k < 2 * D; k++) begin
      for (int i = 0; i < L; i++) begin
        s_re[i] = (k < D) ? W'(-2048) : W'(2047);
        s_im[i] = s_re[i];
        d_re[i] = s_re[i];
        d_im[i] = '0;
      end
      tick(1'b1);
      if (k == D) begin
        chk("ext_add_re0", 32'(o_add_re[0]), -1);
        chk("ext_sub_re0", 32'(o_sub_re[0]), -4095);
        chk("ext_sub_im7", 32'(o_sub_im[7]), -4095);
      end
    end
    clear_in();
    for (int k = 2 * D; k < 2 * D + 10; k++) begin
      tick(1'b0);
      if (k == 2 * D) begin
        chk("ext_d_sub_re5", 32'(o_sub_re[5]), 0);
        chk("ext_d_sub_im5", 32'(o_sub_im[5]), 4095);
        chk("ext_d_add_re5", 32'(o_add_re[5]), -1);
      end
    end

    // Three back-to-back random bursts
    vld_seen = 0;
    for (int k = 0; k < 6 * D; k++) begin
      rand_in();
      tick(1'b1);
    end
    clear_in();
    repeat (12) tick(1'b0);
    chk("b2b_vld_count", vld_seen, 48);

    // Gaps: 3 cycles inside FILL, 2 inside CALC, garbage on the gap inputs
    vld_seen = 0;
    for (int c = 0; c < 2 * D + 5; c++) begin
      rand_in();
      tick(!((c >= 4 && c < 7) || (c >= 15 && c < 17)));
    end
    clear_in();
    repeat (12) tick(1'b0);
    chk("gap_vld_count", vld_seen, 16);

    // Reset during an active drain discards it
    for (int k = 0; k < 2 * D; k++) begin
      rand_in();
      tick(1'b1);
    end
    repeat (3) tick(1'b0);
    do_reset();
    vld_seen = 0;
    repeat (8) tick(1'b0);
    chk("drain_rst_vld_count", vld_seen, 0);

    // Reset mid-burst at in_cnt = 11, then a fresh burst
    for (int k = 0; k < 11; k++) begin
      rand_in();
      tick(1'b1);
    end
    do_reset();
    vld_seen = 0;
    for (int k = 0; k < 2 * D; k++) begin
      rand_in();
      tick(1'b1);
    end
    clear_in();
    repeat (12) tick(1'b0);
    chk("fresh_vld_count", vld_seen, 16);
    chk("sb_empty_at_end", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
